// File: rtl/bus_pkg.sv
// Shared bus definitions: beat width (overridable via `BUS_WIDTH) and default
// packing depth for the width unpacker.
`ifndef BUS_WIDTH
`define BUS_WIDTH 8
`endif

package bus_pkg;
  localparam int BUS_WIDTH     = `BUS_WIDTH;
  localparam int DEFAULT_BEATS = 4;

  typedef logic [BUS_WIDTH-1:0] beat_t;
endpackage

// File: rtl/bus_word_slot.sv
// Word-wide register with a valid flag. It holds its contents unless it is told
// to load or clear; a load takes precedence over a clear.
module bus_word_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         load_valid,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= load_valid;
    end else if (clear) begin
      q     <= '0;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/bus_width_unpacker_rx.sv
// Packs narrow valid/ready beats into wide words of up to BEATS lanes, with an
// accumulator slot feeding an output slot so words stream without bubbles.
module bus_width_unpacker_rx
  import bus_pkg::*;
#(
  parameter int  bus_width = BUS_WIDTH,
  parameter int  BEATS     = DEFAULT_BEATS,
  localparam int CNT_W     = $clog2(BEATS + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [bus_width-1:0]       in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [BEATS*bus_width-1:0] out_data,
  output logic [CNT_W-1:0]           out_nbeats,
  output logic                       out_last
);

  localparam int WORD_W = BEATS * bus_width;
  // Slot layout: {last, nbeats, data}; a partial ACC word keeps the metadata at zero.
  localparam int SLOT_W = WORD_W + CNT_W + 1;

  logic [CNT_W-1:0]  count;
  logic              acc_full;
  logic [SLOT_W-1:0] acc_q, acc_d, out_q, out_d, done_word;
  logic [WORD_W-1:0] merged;
  logic              acc_load, acc_load_valid, acc_clear;
  logic              out_load, out_clear;
  logic              in_fire, out_free, complete;

  assign in_ready = !acc_full;
  assign in_fire  = in_valid && !acc_full;
  assign out_free = !out_valid || out_ready;
  assign complete = in_fire && (in_last || (count == CNT_W'(BEATS - 1)));

  always_comb begin
    merged = acc_q[WORD_W-1:0];
    merged[int'(count)*bus_width +: bus_width] = in_data;
    done_word = {in_last, count + CNT_W'(1), merged};
  end

  always_comb begin
    acc_load       = 1'b0;
    acc_load_valid = 1'b0;
    acc_clear      = 1'b0;
    out_load       = 1'b0;
    out_clear      = 1'b0;
    acc_d          = done_word;
    out_d          = done_word;
    if (acc_full) begin
      if (out_free) begin
        out_load  = 1'b1;
        out_d     = acc_q;
        acc_clear = 1'b1;
      end
    end else if (in_fire) begin
      if (complete && out_free) begin
        out_load  = 1'b1;
        acc_clear = 1'b1;
      end else if (complete) begin
        acc_load       = 1'b1;
        acc_load_valid = 1'b1;
      end else begin
        acc_load = 1'b1;
        acc_d    = {1'b0, CNT_W'(0), merged};
      end
    end
    if (!out_load && out_valid && out_ready)
      out_clear = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (in_fire)
      count <= complete ? '0 : count + CNT_W'(1);
  end

  bus_word_slot #(.W(SLOT_W)) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (acc_load),
    .load_valid (acc_load_valid),
    .clear      (acc_clear),
    .d          (acc_d),
    .q          (acc_q),
    .valid      (acc_full)
  );

  bus_word_slot #(.W(SLOT_W)) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (out_load),
    .load_valid (1'b1),
    .clear      (out_clear),
    .d          (out_d),
    .q          (out_q),
    .valid      (out_valid)
  );

  assign out_data   = out_q[WORD_W-1:0];
  assign out_nbeats = out_q[WORD_W +: CNT_W];
  assign out_last   = out_q[SLOT_W-1];

endmodule

// File: tb/tb_bus_width_unpacker_rx.sv
// Self-checking bench: a queue-based word model is compared against the DUT on
// every negedge, plus literal checks on directed words.
module tb_bus_width_unpacker_rx;

  localparam int BW    = 8;
  localparam int BEATS = 4;
  localparam int CNT_W = $clog2(BEATS + 1);

  typedef struct {
    logic [BEATS*BW-1:0] data;
    logic [CNT_W-1:0]    nbeats;
    logic                last;
  } word_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [BW-1:0]         in_data = '0;
  logic                  in_last = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [BEATS*BW-1:0]   out_data;
  logic [CNT_W-1:0]      out_nbeats;
  logic                  out_last;

  int tests = 0;
  int fails = 0;

  word_t         exp_q[$];
  logic [BW-1:0] cur[$];
  word_t         got[$];
  logic          pend_in = 1'b0, pend_out = 1'b0;
  logic          pend_in_last = 1'b0;
  logic [BW-1:0] pend_in_data = '0;

  bus_width_unpacker_rx #(.bus_width(BW), .BEATS(BEATS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_nbeats (out_nbeats),
    .out_last   (out_last)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: completed-but-undelivered words; ACC+OUT can hold at most two.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cur.delete();
      pend_in  = 1'b0;
      pend_out = 1'b0;
      check_output("reset_out_valid", 64'(out_valid), 64'd0);
      check_output("reset_in_ready", 64'(in_ready), 64'd1);
      check_output("reset_out_data", 64'(out_data), 64'd0);
      check_output("reset_out_nbeats", 64'(out_nbeats), 64'd0);
      check_output("reset_out_last", 64'(out_last), 64'd0);
    end else begin
      if (pend_out) void'(exp_q.pop_front());
      if (pend_in) begin
        cur.push_back(pend_in_data);
        if (pend_in_last || cur.size() == BEATS) begin
          word_t w;
          w.data   = '0;
          for (int i = 0; i < cur.size(); i++) w.data[i*BW +: BW] = cur[i];
          w.nbeats = CNT_W'(cur.size());
          w.last   = pend_in_last;
          exp_q.push_back(w);
          cur.delete();
        end
      end
      check_output("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
      check_output("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      if (exp_q.size() > 0) begin
        check_output("out_data", 64'(out_data), 64'(exp_q[0].data));
        check_output("out_nbeats", 64'(out_nbeats), 64'(exp_q[0].nbeats));
        check_output("out_last", 64'(out_last), 64'(exp_q[0].last));
      end
      pend_in      = in_valid && (exp_q.size() < 2);
      pend_in_data = in_data;
      pend_in_last = in_last;
      pend_out     = out_ready && (exp_q.size() > 0);
      if (out_valid && out_ready) begin
        word_t a;
        a.data   = out_data;
        a.nbeats = out_nbeats;
        a.last   = out_last;
        got.push_back(a);
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 just after the accepting edge.
  task automatic apply_stimulus(input logic [BW-1:0] d, input logic l);
    int waits = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 300) begin
      tests++;
      fails++;
      $display("[TB] FAIL beat_accept_timeout: in_ready stuck at 0, expected 1");
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int waits = 0;
    @(negedge clk);
    while (out_valid && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 300) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: out_valid stuck at 1, expected 0");
    end
    @(posedge clk);
    #2;
  endtask

  task automatic check_word(input string name, input logic [31:0] d, input int n, input logic l);
    check_output({name, "_data"}, 64'(got[got.size()-1].data), 64'(d));
    check_output({name, "_nbeats"}, 64'(got[got.size()-1].nbeats), 64'(n));
    check_output({name, "_last"}, 64'(got[got.size()-1].last), 64'(l));
  endtask

  logic stop_rand = 1'b0;
  int   stim_words = 0;
  int   base;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    out_ready = 1'b1;
    base = got.size();
    apply_stimulus(8'h11, 1'b0);
    apply_stimulus(8'h22, 1'b0);
    apply_stimulus(8'h33, 1'b0);
    apply_stimulus(8'h44, 1'b0);
    wait_drain();
    check_output("full_word_count", 64'(got.size() - base), 64'd1);
    check_word("full_word", 32'h44332211, 4, 1'b0);

    apply_stimulus(8'hAA, 1'b0);
    apply_stimulus(8'hBB, 1'b1);
    wait_drain();
    check_word("short_word", 32'h0000BBAA, 2, 1'b1);

    out_ready = 1'b0;
    base = got.size();
    for (int i = 1; i <= 8; i++) apply_stimulus(8'(8'h80 + i), 1'b0);
    repeat (3) @(negedge clk);
    check_output("stall_in_ready", 64'(in_ready), 64'd0);
    check_output("stall_no_delivery", 64'(got.size() - base), 64'd0);
    check_output("stall_out_data", 64'(out_data), 64'h84838281);
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain();
    check_output("stall_delivered", 64'(got.size() - base), 64'd2);
    if (got.size() - base == 2) begin
      check_output("stall_word0", 64'(got[base].data), 64'h84838281);
      check_output("stall_word1", 64'(got[base+1].data), 64'h88878685);
    end

    apply_stimulus(8'h5A, 1'b1);
    wait_drain();
    check_word("single_beat", 32'h0000005A, 1, 1'b1);

    apply_stimulus(8'h01, 1'b0);
    apply_stimulus(8'h02, 1'b0);
    apply_stimulus(8'h03, 1'b0);
    apply_stimulus(8'h04, 1'b1);
    wait_drain();
    check_word("last_on_final_beat", 32'h04030201, 4, 1'b1);

    base = got.size();
    fork
      begin
        int in_word = 0;
        for (int i = 0; i < 400; i++) begin
          logic l;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #2;
          end
          l = ($urandom_range(0, 5) == 0) || (i == 399);
          apply_stimulus(8'($urandom), l);
          in_word++;
          if (l || in_word == BEATS) begin
            stim_words++;
            in_word = 0;
          end
        end
        stop_rand = 1'b1;
      end
      begin
        while (!stop_rand) begin
          @(posedge clk);
          #2 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    check_output("random_word_count", 64'(got.size() - base), 64'(stim_words));

    apply_stimulus(8'hE1, 1'b0);
    apply_stimulus(8'hE2, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;
    base = got.size();
    apply_stimulus(8'h01, 1'b0);
    apply_stimulus(8'h02, 1'b0);
    apply_stimulus(8'h03, 1'b0);
    apply_stimulus(8'h04, 1'b0);
    wait_drain();
    repeat (2) @(posedge clk);
    check_output("post_reset_count", 64'(got.size() - base), 64'd1);
    check_word("post_reset_word", 32'h04030201, 4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_width_unpacker_rx.md
Name: bus_width_unpacker_rx

Overview:
- Receive-side companion to the `BUS_WIDTH`-parameterised bus producer.
- Accepts narrow beats of `bus_width` bits over a valid/ready stream.
- Reassembles up to BEATS beats into one wide word and presents it downstream over a second valid/ready stream.
- Sits between the narrow configurable bus and wide internal datapath consumers.

Parameters:
- bus_width, default `BUS_WIDTH (package fallback 8 if undefined): width of one input beat.
- BEATS, default 4: maximum beats packed per output word; must be ≥2.
- CNT_W, default $clog2(BEATS+1): width of the beat-count field; localparam, not overridable.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  bus_width  input beat payload.
- in_last  in  1  beat terminates the current word early (short word).
- out_valid  out  1  packed word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  BEATS*bus_width  packed word; beat k in bits [k*bus_width +: bus_width].
- out_nbeats  out  CNT_W  number of valid beats in out_data, 1..BEATS.
- out_last  out  1  word was closed by in_last, not by reaching BEATS.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, out_nbeats=0, out_last=0.
  - Accumulator count=0, acc_full=0, so in_ready=1 from the first cycle after reset.
- Input transfer occurs on a rising edge with in_valid && in_ready. Output transfer occurs with out_valid && out_ready.
- Storage is two word-wide registers: an accumulator (ACC) and an output register (OUT).
- ACC lane rules:
  - Beat at count c is written into lane c.
  - Lanes above the final count read zero; ACC is cleared when its word moves to OUT.
- Word completes on acceptance of a beat with count==BEATS-1 or in_last=1.
- On completion at edge N:
  - If OUT is free (!out_valid, or out_valid && out_ready at N), the completed word, including the final beat, loads into OUT at edge N. out_valid=1 after N, so latency from final beat to out_valid is 0 extra cycles. ACC resets to count 0.
  - Otherwise ACC holds the complete word and acc_full=1.
- in_ready = !acc_full, combinational from a register; no combinational path from in_valid or out_ready.
- While acc_full: move ACC to OUT on the first edge where OUT is free. acc_full clears at that edge, so in_ready=1 the following cycle.
- Sustained throughput: one beat per cycle when out_ready is held 1. No bubbles between words.
- in_last on the first beat gives a word with out_nbeats=1 and out_last=1.
- in_last on beat BEATS-1 gives out_nbeats=BEATS and out_last=1; in_last takes precedence for the flag.
- OUT contents and out_valid are stable while out_valid && !out_ready.
- in_valid with in_ready=0 has no effect; the upstream holds the data.
- Reset mid-word discards the partial ACC and any pending OUT word. No output is produced for them.
- Beat count never exceeds BEATS-1 in ACC; wrap to 0 only on completion.

Decomposition:
- Shared package bus_pkg holds:
  - BUS_WIDTH localparam, from the `BUS_WIDTH define with `ifndef fallback 8.
  - typedef logic [BUS_WIDTH-1:0] beat_t.
  - Default BEATS constant.
- One sub-module is natural: bus_word_slot, a word register with valid, hold-when-stalled and load/clear controls. It is instantiated twice, for ACC and OUT.

Test Plan:
- Reset then 4 beats 0x11,0x22,0x33,0x44 with out_ready=1 → out_data=0x44332211, out_nbeats=4, out_last=0, out_valid on the edge after the 4th beat; in_ready never drops.
- Beats 0xAA, 0xBB with in_last on 0xBB → out_data=0x0000BBAA, out_nbeats=2, out_last=1.
- out_ready=0 while 8 beats are offered → first word held stable in OUT; second word fills ACC; in_ready=0 after beat 8. Raising out_ready → both words delivered in order, in_ready=1 the cycle after ACC drains.
- in_last on the first beat 0x5A → out_data=0x0000005A, out_nbeats=1, out_last=1.
- Streaming 400 random beats with random in_valid/out_ready → scoreboard matches every word; no beat lost or duplicated.
- Assert rst_n low after 2 beats, then release and send 4 beats 0x01..0x04 → only 0x04030201 emitted; no stale data.
